// File: rtl/dm_arbiter.sv
// Two-port round-robin arbiter in front of the data memory, with a bounded
// burst lock for master 1, byte-enable generation, range checks and registered responses.
module dm_arbiter #(
    parameter int unsigned DEPTH_WORDS = 12288,
    parameter int unsigned MAX_BURST   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [1:0]  m0_size,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [31:0] m0_pc,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [1:0]  m1_size,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic        m1_lock,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic        m0_rerr,
    output logic [31:0] m0_rdata,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic        m1_rerr,
    output logic [31:0] m1_rdata,
    output logic [31:0] dm_pc,
    output logic [13:0] dm_addr,
    output logic [31:0] dm_wdata,
    output logic [3:0]  dm_memwrite,
    input  logic [31:0] dm_out
);

    localparam int unsigned CNT_W = 8;

    logic             last_q, last_d;
    logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
    logic             burst_hold;
    logic             any_gnt;
    logic             sel_we, sel_err;
    logic [1:0]       sel_size;
    logic [31:0]      sel_addr, sel_wdata;
    logic [31:0]      resp_data;
    logic             m0_rvalid_q, m0_rerr_q, m1_rvalid_q, m1_rerr_q;
    logic [31:0]      m0_rdata_q, m1_rdata_q;

    function automatic logic acc_err(input logic [1:0] size, input logic [31:0] addr);
        logic e;
        case (size)
            2'b01:   e = addr[0];
            2'b10:   e = |addr[1:0];
            2'b11:   e = 1'b1;
            default: e = 1'b0;
        endcase
        if (32'(addr[31:2]) >= DEPTH_WORDS) e = 1'b1;
        return e;
    endfunction

    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lo);
        logic [3:0] be;
        case (size)
            2'b00:   be = 4'b0001 << lo;
            2'b01:   be = lo[1] ? 4'b1100 : 4'b0011;
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] load_data(input logic [1:0] size, input logic [1:0] lo,
                                              input logic [31:0] word);
        logic [31:0] sh;
        logic [31:0] d;
        sh = word >> {lo, 3'b000};
        case (size)
            2'b00:   d = {24'd0, sh[7:0]};
            2'b01:   d = lo[1] ? {16'd0, word[31:16]} : {16'd0, word[15:0]};
            2'b10:   d = word;
            default: d = 32'd0;
        endcase
        return d;
    endfunction

    // Arbitration: an active burst lock beats round-robin until MAX_BURST is reached
    always_comb begin
        burst_hold = m1_req && (burst_cnt_q != '0) && (32'(burst_cnt_q) < MAX_BURST);
        m0_gnt     = !reset && m0_req && !burst_hold && (!m1_req || last_q);
        m1_gnt     = !reset && m1_req && !m0_gnt;
    end

    always_comb begin
        any_gnt     = m0_gnt | m1_gnt;
        sel_we      = m1_gnt ? m1_we    : m0_we;
        sel_size    = m1_gnt ? m1_size  : m0_size;
        sel_addr    = m1_gnt ? m1_addr  : m0_addr;
        sel_wdata   = m1_gnt ? m1_wdata : m0_wdata;
        sel_err     = acc_err(sel_size, sel_addr);
        dm_memwrite = 4'b0000;
        dm_addr     = 14'd0;
        dm_wdata    = 32'd0;
        dm_pc       = 32'd0;
        resp_data   = 32'd0;
        last_d      = last_q;
        burst_cnt_d = '0;
        if (any_gnt) begin
            dm_addr  = sel_addr[15:2];
            dm_wdata = sel_wdata;
            if (sel_we && !sel_err) dm_memwrite = byte_en(sel_size, sel_addr[1:0]);
        end
        if (m0_gnt) dm_pc = m0_pc;
        if (!sel_we && !sel_err) resp_data = load_data(sel_size, sel_addr[1:0], dm_out);
        if (m0_gnt)      last_d = 1'b0;
        else if (m1_gnt) last_d = 1'b1;
        // A lock grant after the burst limit starts a fresh burst
        if (m1_gnt && m1_lock)
            burst_cnt_d = (32'(burst_cnt_q) >= MAX_BURST) ? CNT_W'(1) : burst_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_q      <= 1'b1;
            burst_cnt_q <= '0;
            m0_rvalid_q <= 1'b0;
            m0_rerr_q   <= 1'b0;
            m0_rdata_q  <= 32'd0;
            m1_rvalid_q <= 1'b0;
            m1_rerr_q   <= 1'b0;
            m1_rdata_q  <= 32'd0;
        end else begin
            last_q      <= last_d;
            burst_cnt_q <= burst_cnt_d;
            m0_rvalid_q <= m0_gnt;
            m1_rvalid_q <= m1_gnt;
            if (m0_gnt) begin
                m0_rerr_q  <= sel_err;
                m0_rdata_q <= resp_data;
            end
            if (m1_gnt) begin
                m1_rerr_q  <= sel_err;
                m1_rdata_q <= resp_data;
            end
        end
    end

    assign m0_rvalid = m0_rvalid_q;
    assign m0_rerr   = m0_rerr_q;
    assign m0_rdata  = m0_rdata_q;
    assign m1_rvalid = m1_rvalid_q;
    assign m1_rerr   = m1_rerr_q;
    assign m1_rdata  = m1_rdata_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: directed scenarios plus randomized traffic checked
// against a byte-addressed memory and rule-level arbitration model.
module tb_dm_arbiter;

    localparam int unsigned DEPTH = 12288;
    localparam int unsigned MAXB  = 4;

    logic        clk, reset;
    logic        m0_req, m0_we, m1_req, m1_we, m1_lock;
    logic [1:0]  m0_size, m1_size;
    logic [31:0] m0_addr, m0_wdata, m0_pc, m1_addr, m1_wdata;
    logic        m0_gnt, m0_rvalid, m0_rerr, m1_gnt, m1_rvalid, m1_rerr;
    logic [31:0] m0_rdata, m1_rdata, dm_pc, dm_wdata, dm_out;
    logic [13:0] dm_addr;
    logic [3:0]  dm_memwrite;

    int unsigned pass_cnt = 0;
    int unsigned total_cnt = 0;

    logic [31:0] mem     [0:16383];
    logic [31:0] ref_mem [0:16383];
    logic        tb_init;
    logic [31:0] wr_v, wr_nw;
    int unsigned wr_sh;

    dm_arbiter #(.DEPTH_WORDS(DEPTH), .MAX_BURST(MAXB)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_size(m0_size), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_pc(m0_pc),
        .m1_req(m1_req), .m1_we(m1_we), .m1_size(m1_size), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_lock(m1_lock),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rerr(m0_rerr), .m0_rdata(m0_rdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rerr(m1_rerr), .m1_rdata(m1_rdata),
        .dm_pc(dm_pc), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_memwrite(dm_memwrite), .dm_out(dm_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // DM model: low-aligned store data is placed onto the enabled lanes
    assign dm_out = mem[dm_addr];
    always @(posedge clk) begin
        if (tb_init) begin
            for (int i = 0; i < 16384; i++) mem[i] <= 32'(i) * 32'h9E3779B1 + 32'h01234567;
        end else if (dm_memwrite != 4'b0000) begin
            wr_sh = dm_memwrite[0] ? 0 : dm_memwrite[1] ? 1 : dm_memwrite[2] ? 2 : 3;
            wr_v  = dm_wdata << (8 * wr_sh);
            wr_nw = mem[dm_addr];
            for (int k = 0; k < 4; k++) if (dm_memwrite[k]) wr_nw[8*k +: 8] = wr_v[8*k +: 8];
            mem[dm_addr] <= wr_nw;
        end
    end

    function automatic bit ref_err(input logic [1:0] size, input logic [31:0] addr);
        int unsigned n;
        if (size == 2'b11) return 1'b1;
        n = 1 << size;
        return ((addr % n) != 0) || ((addr / 4) >= DEPTH);
    endfunction

    function automatic logic [3:0] ref_be(input logic we, input logic [1:0] size, input logic [31:0] addr);
        logic [3:0] be;
        be = 4'b0000;
        if (we && !ref_err(size, addr))
            for (int i = 0; i < (1 << size); i++) be[(addr % 4) + i] = 1'b1;
        return be;
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] size, input logic [31:0] addr);
        logic [31:0] v, w;
        v = 32'd0;
        w = ref_mem[addr / 4];
        for (int i = 0; i < (1 << size); i++) v[8*i +: 8] = w[8*((addr % 4) + i) +: 8];
        return v;
    endfunction

    task automatic ref_store(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] d);
        logic [31:0] w;
        w = ref_mem[addr / 4];
        for (int i = 0; i < (1 << size); i++) w[8*((addr % 4) + i) +: 8] = d[8*i +: 8];
        ref_mem[addr / 4] = w;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        m0_req = 0; m0_we = 0; m0_size = 0; m0_addr = 0; m0_wdata = 0; m0_pc = 0;
        m1_req = 0; m1_we = 0; m1_size = 0; m1_addr = 0; m1_wdata = 0; m1_lock = 0;
    endtask

    task automatic drive_m0(input logic we, input logic [1:0] size, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] pc);
        m0_req = 1; m0_we = we; m0_size = size; m0_addr = addr; m0_wdata = wdata; m0_pc = pc;
    endtask

    task automatic drive_m1(input logic we, input logic [1:0] size, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic lock);
        m1_req = 1; m1_we = we; m1_size = size; m1_addr = addr; m1_wdata = wdata; m1_lock = lock;
    endtask

    task automatic do_reset();
        idle_all();
        reset = 1; tb_init = 1;
        for (int i = 0; i < 16384; i++) ref_mem[i] = 32'(i) * 32'h9E3779B1 + 32'h01234567;
        step(); step();
        reset = 0; tb_init = 0;
    endtask

    task automatic test_reset();
        do_reset();
        reset = 1;
        drive_m0(1, 2'b10, 32'h20, 32'h55, 32'h40);
        drive_m1(1, 2'b10, 32'h24, 32'h66, 1);
        #2;
        total_cnt++; if ({m0_gnt, m1_gnt} !== 2'b00) $display("FAIL rst_gnt got %b exp 00", {m0_gnt, m1_gnt}); else pass_cnt++;
        total_cnt++; if (dm_memwrite !== 4'b0000) $display("FAIL rst_memwrite got %b exp 0000", dm_memwrite); else pass_cnt++;
        total_cnt++; if (dm_addr !== 14'd0) $display("FAIL rst_dm_addr got %h exp 0", dm_addr); else pass_cnt++;
        step();
        total_cnt++; if ({m0_rvalid, m0_rerr, m1_rvalid, m1_rerr} !== 4'b0000) $display("FAIL rst_resp got %b exp 0000", {m0_rvalid, m0_rerr, m1_rvalid, m1_rerr}); else pass_cnt++;
        total_cnt++; if ((m0_rdata | m1_rdata) !== 32'd0) $display("FAIL rst_rdata got %h/%h exp 0", m0_rdata, m1_rdata); else pass_cnt++;
        idle_all();
        reset = 0;
    endtask

    task automatic test_word();
        drive_m0(1, 2'b10, 32'h10, 32'hDEADBEEF, 32'h100);
        #2;
        total_cnt++; if ({m0_gnt, m1_gnt} !== 2'b10) $display("FAIL word_gnt got %b exp 10", {m0_gnt, m1_gnt}); else pass_cnt++;
        total_cnt++; if (dm_memwrite !== 4'b1111) $display("FAIL word_memwrite got %b exp 1111", dm_memwrite); else pass_cnt++;
        total_cnt++; if (dm_addr !== 14'h004) $display("FAIL word_dm_addr got %h exp 004", dm_addr); else pass_cnt++;
        total_cnt++; if (dm_wdata !== 32'hDEADBEEF) $display("FAIL word_dm_wdata got %h exp deadbeef", dm_wdata); else pass_cnt++;
        total_cnt++; if (dm_pc !== 32'h100) $display("FAIL word_dm_pc got %h exp 100", dm_pc); else pass_cnt++;
        step();
        total_cnt++; if ({m0_rvalid, m0_rerr, m1_rvalid} !== 3'b100) $display("FAIL word_st_resp got %b exp 100", {m0_rvalid, m0_rerr, m1_rvalid}); else pass_cnt++;
        total_cnt++; if (m0_rdata !== 32'd0) $display("FAIL word_st_rdata got %h exp 0", m0_rdata); else pass_cnt++;
        drive_m0(0, 2'b10, 32'h10, 32'h0, 32'h104);
        step();
        total_cnt++; if (m0_rdata !== 32'hDEADBEEF) $display("FAIL word_ld_rdata got %h exp deadbeef", m0_rdata); else pass_cnt++;
        idle_all();
        step();
        total_cnt++; if (m0_rvalid !== 1'b0) $display("FAIL word_rvalid_pulse got %b exp 0", m0_rvalid); else pass_cnt++;
    endtask

    task automatic test_subword();
        drive_m0(1, 2'b00, 32'h13, 32'hAA, 32'h200);
        #2;
        total_cnt++; if (dm_memwrite !== 4'b1000) $display("FAIL sub_byte_memwrite got %b exp 1000", dm_memwrite); else pass_cnt++;
        step();
        drive_m0(0, 2'b01, 32'h12, 32'h0, 32'h204);
        step();
        total_cnt++; if (m0_rdata !== 32'h0000AAAD) $display("FAIL sub_half_ld got %h exp 0000aaad", m0_rdata); else pass_cnt++;
        drive_m0(1, 2'b01, 32'h11, 32'h1234, 32'h208);
        #2;
        total_cnt++; if ({m0_gnt, dm_memwrite} !== 5'b10000) $display("FAIL sub_misal_gnt_we got %b exp 10000", {m0_gnt, dm_memwrite}); else pass_cnt++;
        step();
        total_cnt++; if ({m0_rvalid, m0_rerr} !== 2'b11 || m0_rdata !== 32'd0) $display("FAIL sub_misal_resp got %b/%h exp 11/0", {m0_rvalid, m0_rerr}, m0_rdata); else pass_cnt++;
        drive_m0(0, 2'b00, 32'h13, 32'h0, 32'h20C);
        step();
        total_cnt++; if ({m0_rerr, m0_rdata} !== {1'b0, 32'h000000AA}) $display("FAIL sub_byte_ld got %b/%h exp 0/000000aa", m0_rerr, m0_rdata); else pass_cnt++;
        idle_all();
    endtask

    task automatic test_burst();
        logic [10:0] exp_m1;
        do_reset();
        exp_m1 = 11'b01111011110;  // bit i = master 1 expected in cycle i
        drive_m0(0, 2'b10, 32'h40, 32'h0, 32'h300);
        drive_m1(0, 2'b10, 32'h44, 32'h0, 1);
        for (int i = 0; i < 11; i++) begin
            #2;
            total_cnt++;
            if ({m0_gnt, m1_gnt} !== {~exp_m1[i], exp_m1[i]})
                $display("FAIL burst_seq[%0d] got %b exp %b", i, {m0_gnt, m1_gnt}, {~exp_m1[i], exp_m1[i]});
            else pass_cnt++;
            step();
        end
        idle_all();
    endtask

    task automatic test_contention();
        do_reset();
        drive_m0(0, 2'b10, 32'h40, 32'h0, 32'h400);
        drive_m1(0, 2'b10, 32'h44, 32'h0, 0);
        for (int i = 0; i < 6; i++) begin
            #2;
            total_cnt++;
            if ({m0_gnt, m1_gnt} !== ((i % 2 == 0) ? 2'b10 : 2'b01))
                $display("FAIL contend_seq[%0d] got %b exp %b", i, {m0_gnt, m1_gnt}, (i % 2 == 0) ? 2'b10 : 2'b01);
            else pass_cnt++;
            step();
        end
        idle_all();
    endtask

    task automatic test_range();
        drive_m0(0, 2'b10, 32'h0000C000, 32'h0, 32'h500);
        #2;
        total_cnt++; if ({m0_gnt, dm_memwrite, dm_addr} !== {1'b1, 4'b0000, 14'h3000}) $display("FAIL range_oob_dm got %b/%b/%h exp 1/0000/3000", m0_gnt, dm_memwrite, dm_addr); else pass_cnt++;
        step();
        total_cnt++; if ({m0_rvalid, m0_rerr} !== 2'b11 || m0_rdata !== 32'd0) $display("FAIL range_oob_resp got %b/%h exp 11/0", {m0_rvalid, m0_rerr}, m0_rdata); else pass_cnt++;
        idle_all();
        drive_m1(1, 2'b10, 32'h0000BFFC, 32'h12345678, 0);
        #2;
        total_cnt++; if ({m1_gnt, dm_memwrite, dm_addr} !== {1'b1, 4'b1111, 14'h2FFF}) $display("FAIL range_last_dm got %b/%b/%h exp 1/1111/2fff", m1_gnt, dm_memwrite, dm_addr); else pass_cnt++;
        step();
        total_cnt++; if ({m1_rvalid, m1_rerr} !== 2'b10) $display("FAIL range_last_resp got %b exp 10", {m1_rvalid, m1_rerr}); else pass_cnt++;
        drive_m1(0, 2'b11, 32'h20, 32'h0, 0);
        step();
        total_cnt++; if ({m1_rvalid, m1_rerr} !== 2'b11 || m1_rdata !== 32'd0) $display("FAIL range_size3 got %b/%h exp 11/0", {m1_rvalid, m1_rerr}, m1_rdata); else pass_cnt++;
        idle_all();
        drive_m0(1, 2'b10, 32'h0000C000, 32'hFFFFFFFF, 32'h504);
        #2;
        total_cnt++; if (dm_memwrite !== 4'b0000) $display("FAIL range_oob_st got %b exp 0000", dm_memwrite); else pass_cnt++;
        step();
        idle_all();
    endtask

    task automatic test_reset_mid();
        drive_m1(0, 2'b10, 32'h0000BFFC, 32'h0, 0);
        #2;
        total_cnt++; if (m1_gnt !== 1'b1) $display("FAIL rmid_gnt got %b exp 1", m1_gnt); else pass_cnt++;
        step();
        reset = 1;
        drive_m0(0, 2'b10, 32'h40, 32'h0, 32'h600);
        #2;
        total_cnt++; if ({m0_gnt, m1_gnt, dm_memwrite, dm_addr, dm_pc} !== 52'd0) $display("FAIL rmid_comb got %b%b/%b/%h/%h exp 0", m0_gnt, m1_gnt, dm_memwrite, dm_addr, dm_pc); else pass_cnt++;
        step();
        total_cnt++; if ({m1_rvalid, m1_rerr, m1_rdata} !== 34'd0) $display("FAIL rmid_drop got %b/%b/%h exp 0", m1_rvalid, m1_rerr, m1_rdata); else pass_cnt++;
        reset = 0;
        #2;
        total_cnt++; if ({m0_gnt, m1_gnt} !== 2'b10) $display("FAIL rmid_first got %b exp 10", {m0_gnt, m1_gnt}); else pass_cnt++;
        step();
        idle_all();
        step();
    endtask

    task automatic test_random();
        logic        p_req[2], p_we[2];
        logic [1:0]  p_size[2];
        logic [31:0] p_addr[2], p_wdata[2];
        logic [31:0] pc;
        logic        lock, hold, e_err;
        logic [31:0] e_data;
        int          g, m_last, m_run;
        bit          m_prev_locked;
        int unsigned r;
        do_reset();
        m_last = 1; m_run = 0; m_prev_locked = 0;
        p_req[0] = 0; p_req[1] = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int m = 0; m < 2; m++) begin
                if (!p_req[m] && $urandom_range(99) < 65) begin
                    p_req[m] = 1;
                    p_we[m]  = 1'($urandom_range(1));
                    r = $urandom_range(15);
                    p_size[m] = (r < 5) ? 2'b00 : (r < 10) ? 2'b01 : (r < 15) ? 2'b10 : 2'b11;
                    if ($urandom_range(15) == 0) p_addr[m] = 32'h0000BFF0 + 32'($urandom_range(31));
                    else p_addr[m] = 32'h80 + 32'($urandom_range(63));
                    p_wdata[m] = $urandom;
                end
            end
            pc = $urandom;
            lock = ($urandom_range(3) != 0);
            idle_all();
            if (p_req[0]) drive_m0(p_we[0], p_size[0], p_addr[0], p_wdata[0], pc);
            if (p_req[1]) drive_m1(p_we[1], p_size[1], p_addr[1], p_wdata[1], lock);
            m1_lock = lock;
            #2;
            hold = p_req[1] && m_prev_locked && (m_run < MAXB);
            if (hold) g = 1;
            else if (p_req[0] && p_req[1]) g = (m_last == 1) ? 0 : 1;
            else if (p_req[0]) g = 0;
            else if (p_req[1]) g = 1;
            else g = -1;
            total_cnt++;
            if ({m0_gnt, m1_gnt} !== {g == 0, g == 1}) $display("FAIL rnd_gnt cyc %0d got %b exp %b", cyc, {m0_gnt, m1_gnt}, {g == 0, g == 1}); else pass_cnt++;
            if (g >= 0) begin
                total_cnt++;
                if (dm_memwrite !== ref_be(p_we[g], p_size[g], p_addr[g])) $display("FAIL rnd_be cyc %0d got %b exp %b", cyc, dm_memwrite, ref_be(p_we[g], p_size[g], p_addr[g])); else pass_cnt++;
                total_cnt++;
                if (dm_addr !== 14'(p_addr[g] / 4)) $display("FAIL rnd_dm_addr cyc %0d got %h exp %h", cyc, dm_addr, 14'(p_addr[g] / 4)); else pass_cnt++;
                total_cnt++;
                if (dm_pc !== ((g == 0) ? pc : 32'd0)) $display("FAIL rnd_dm_pc cyc %0d got %h exp %h", cyc, dm_pc, (g == 0) ? pc : 32'd0); else pass_cnt++;
                e_err  = ref_err(p_size[g], p_addr[g]);
                e_data = (p_we[g] || e_err) ? 32'd0 : ref_load(p_size[g], p_addr[g]);
                if (p_we[g] && !e_err) ref_store(p_size[g], p_addr[g], p_wdata[g]);
                m_last = g;
                if (g == 1 && lock) begin
                    m_run = hold ? m_run + 1 : 1;
                    m_prev_locked = 1;
                end else begin
                    m_run = 0; m_prev_locked = 0;
                end
                p_req[g] = 0;
            end else begin
                e_err = 0; e_data = 0;
                m_run = 0; m_prev_locked = 0;
                total_cnt++;
                if ({dm_memwrite, dm_addr} !== 18'd0) $display("FAIL rnd_idle cyc %0d got %b/%h exp 0", cyc, dm_memwrite, dm_addr); else pass_cnt++;
            end
            step();
            total_cnt++;
            if ({m0_rvalid, m1_rvalid} !== {g == 0, g == 1}) $display("FAIL rnd_rvalid cyc %0d got %b exp %b", cyc, {m0_rvalid, m1_rvalid}, {g == 0, g == 1}); else pass_cnt++;
            if (g == 0) begin
                total_cnt++;
                if ({m0_rerr, m0_rdata} !== {e_err, e_data}) $display("FAIL rnd_m0_resp cyc %0d got %b/%h exp %b/%h", cyc, m0_rerr, m0_rdata, e_err, e_data); else pass_cnt++;
            end else if (g == 1) begin
                total_cnt++;
                if ({m1_rerr, m1_rdata} !== {e_err, e_data}) $display("FAIL rnd_m1_resp cyc %0d got %b/%h exp %b/%h", cyc, m1_rerr, m1_rdata, e_err, e_data); else pass_cnt++;
            end
        end
        idle_all();
    endtask

    initial begin
        reset = 1; tb_init = 0;
        idle_all();
        step();
        test_reset();
        test_word();
        test_subword();
        test_range();
        test_reset_mid();
        test_burst();
        test_contention();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
